// File: rtl/apb_pkg.sv
// Shared types and constants for the PSEL2 APB completer and its register bank.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package apb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;

    localparam logic [ADDR_W-1:0] ADDR_WAIT_CFG = 8'hFE;
    localparam logic [ADDR_W-1:0] ADDR_ID       = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    // Transfer attributes captured in the setup phase.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    function automatic logic is_storage(input logic [ADDR_W-1:0] addr, input int depth);
        return int'(addr) < depth;
    endfunction

endpackage

// File: rtl/apb_regbank.sv
// Byte register file plus the 3-bit WAIT_CFG register.
// Latency: writes land on the clock edge; reads are combinational.
// Backpressure: none, every wr_vld is accepted.
module apb_regbank
    import apb_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter int DEFAULT_WAIT = 2
) (
    input  logic              core_clk,
    input  logic              arst_n,
    input  logic              wr_vld,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat,
    output logic [CNT_W-1:0]  wait_cfg
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  wait_q;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wait_q <= CNT_W'(DEFAULT_WAIT);
        end else if (wr_vld) begin
            if (is_storage(wr_addr, DEPTH)) begin
                mem[wr_addr[IDX_W-1:0]] <= wr_dat;
            end else if (wr_addr == ADDR_WAIT_CFG) begin
                wait_q <= wr_dat[CNT_W-1:0];
            end
        end
    end

    always_comb begin
        rd_dat = '0;
        if (is_storage(rd_addr, DEPTH)) begin
            rd_dat = mem[rd_addr[IDX_W-1:0]];
        end else if (rd_addr == ADDR_WAIT_CFG) begin
            rd_dat = {{(DATA_W-CNT_W){1'b0}}, wait_q};
        end
    end

    assign wait_cfg = wait_q;

endmodule

// File: rtl/apb_slave_waitstate.sv
// APB completer for the PSEL2 half of the map: byte registers, WAIT_CFG, ID, error response.
// Latency: PREADY in cycle setup+1+WAIT_CFG, WAIT_CFG sampled at setup.
// Backpressure: PREADY held low during wait states; dropping PSEL mid-wait aborts cleanly.
module apb_slave_waitstate
    import apb_pkg::*;
#(
    parameter int               DEPTH        = 64,
    parameter int               DEFAULT_WAIT = 2,
    parameter logic [DATA_W-1:0] ID_VALUE    = 8'hA5
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    state_t            state_q, state_d;
    req_t              req_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  wait_cfg;
    logic [DATA_W-1:0] rd_dat;
    logic              setup;
    logic              ack;
    logic              err;
    logic              wr_vld;

    assign setup = PSEL & ~PENABLE;

    // Decode works only from the latched request, so bus changes after setup are ignored.
    assign err = ~(is_storage(req_q.addr, DEPTH) || req_q.addr == ADDR_WAIT_CFG ||
                   req_q.addr == ADDR_ID) || (req_q.write && req_q.addr == ADDR_ID);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ack     = 1'b0;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d = (wait_cfg == '0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ack     = PSEL & PENABLE;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            req_q <= '0;
            cnt_q <= '0;
        end else if (state_q == IDLE && setup) begin
            req_q <= '{write: PWRITE, addr: PADDR, wdata: PWDATA};
            cnt_q <= wait_cfg;
        end else if (state_q == WAIT && PSEL) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign wr_vld  = ack & req_q.write & ~err;
    assign PREADY  = ack;
    assign PSLVERR = ack & err;

    always_comb begin
        PRDATA = '0;
        if (ack && !req_q.write && !err) begin
            PRDATA = (req_q.addr == ADDR_ID) ? ID_VALUE : rd_dat;
        end
    end

    apb_regbank #(
        .DEPTH        (DEPTH),
        .DEFAULT_WAIT (DEFAULT_WAIT)
    ) u_regbank (
        .core_clk (PCLK),
        .arst_n   (PRESETn),
        .wr_vld   (wr_vld),
        .wr_addr  (req_q.addr),
        .wr_dat   (req_q.wdata),
        .rd_addr  (req_q.addr),
        .rd_dat   (rd_dat),
        .wait_cfg (wait_cfg)
    );

endmodule

// File: tb/tb_apb_slave_waitstate.sv
// Bench for apb_slave_waitstate: directed test-plan scenarios plus random traffic
// checked against a byte-array model of the address map.
module tb_apb_slave_waitstate;

    localparam int         DEPTH = 64;
    localparam logic [7:0] ID    = 8'hA5;

    // Directed ops packed as {write, addr, wdata}.
    localparam logic [16:0] DIR [15] = '{
        17'h01000, 17'h1053C, 17'h00500, 17'h0FF00, 17'h0FE00,
        17'h1FE00, 17'h00500, 17'h1FE07, 17'h00500, 17'h1FE02,
        17'h1FF11, 17'h14022, 17'h0FF00, 17'h04000, 17'h0FE00
    };

    logic       PCLK    = 1'b0;
    logic       PRESETn = 1'b1;
    logic       PSEL    = 1'b0;
    logic       PENABLE = 1'b0;
    logic       PWRITE  = 1'b0;
    logic [7:0] PADDR   = 8'h00;
    logic [7:0] PWDATA  = 8'h00;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mem_m [256];
    int         wcfg_m;

    apb_slave_waitstate #(
        .DEPTH        (DEPTH),
        .DEFAULT_WAIT (2),
        .ID_VALUE     (ID)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        wcfg_m = 2;
    endtask

    // Expected outcome of one complete transfer, updating the model on a legal write.
    task automatic model_xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                              output logic [7:0] rd, output logic err, output int lat);
        logic legal;
        legal = (int'(a) < DEPTH) || (a == 8'hFE) || (a == 8'hFF);
        err   = !legal || (w && a == 8'hFF);
        lat   = 1 + wcfg_m;
        rd    = 8'h00;
        if (!w && !err) rd = (a == 8'hFF) ? ID : (a == 8'hFE) ? 8'(wcfg_m) : mem_m[a];
        if (w && !err) begin
            if (a == 8'hFE) wcfg_m = int'(d) % 8;
            else mem_m[a] = d;
        end
    endtask

    // Entered #1 after a rising edge; leaves #1 after the edge that ends the completion cycle.
    task automatic do_xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                           output logic [7:0] rd, output logic err, output int lat, output bit tmo);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        lat = 1; tmo = 1'b0; rd = 8'h00; err = 1'b0;
        forever begin
            @(negedge PCLK);
            if (PREADY === 1'b1) begin
                rd = PRDATA; err = PSLVERR;
                break;
            end
            if (lat >= 20) begin
                tmo = 1'b1;
                break;
            end
            @(posedge PCLK); #1;
            lat++;
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge PCLK); #1;
        end
    endtask

    task automatic test_reset();
        #2 PRESETn = 1'b0;
        #1;
        n_tests++;
        if ({PREADY, PSLVERR, PRDATA} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b err=%b rdata=%h, want 0 0 00", PREADY, PSLVERR, PRDATA);
        end
        model_reset();
        @(posedge PCLK); @(posedge PCLK); #1;
        PRESETn = 1'b1;
        idle(1);
    endtask

    task automatic test_directed();
        logic [16:0] op;
        logic [7:0]  rd, erd;
        logic        err, eerr;
        int          lat, elat;
        bit          tmo;
        for (int i = 0; i < 15; i++) begin
            op = DIR[i];
            model_xfer(op[16], op[15:8], op[7:0], erd, eerr, elat);
            do_xfer(op[16], op[15:8], op[7:0], rd, err, lat, tmo);
            n_tests++;
            if (tmo || lat !== elat) begin
                n_fail++;
                $display("FAIL dir%0d_latency: got %0d (timeout=%0d), want %0d", i, lat, tmo, elat);
            end
            n_tests++;
            if (err !== eerr) begin
                n_fail++;
                $display("FAIL dir%0d_pslverr: got %b, want %b", i, err, eerr);
            end
            if (!op[16]) begin
                n_tests++;
                if (rd !== erd) begin
                    n_fail++;
                    $display("FAIL dir%0d_prdata addr %h: got %h, want %h", i, op[15:8], rd, erd);
                end
            end
            idle(1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd, erd;
        logic       err, eerr;
        int         lat, elat;
        bit         tmo;
        for (int i = 1; i <= 3; i++) begin
            model_xfer(1'b1, 8'(i), 8'(8'h50 + i), erd, eerr, elat);
            do_xfer(1'b1, 8'(i), 8'(8'h50 + i), rd, err, lat, tmo);
            n_tests++;
            if (tmo || lat !== elat || err !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_write%0d: got lat %0d err %b, want lat %0d err 0", i, lat, err, elat);
            end
        end
        for (int i = 1; i <= 3; i++) begin
            model_xfer(1'b0, 8'(i), 8'h00, erd, eerr, elat);
            do_xfer(1'b0, 8'(i), 8'h00, rd, err, lat, tmo);
            n_tests++;
            if (tmo || lat !== elat || rd !== erd) begin
                n_fail++;
                $display("FAIL b2b_read%0d: got lat %0d data %h, want lat %0d data %h", i, lat, rd, elat, erd);
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] rd, erd;
        logic       err, eerr;
        int         lat, elat;
        bit         tmo;
        model_xfer(1'b1, 8'hFE, 8'h02, erd, eerr, elat);
        do_xfer(1'b1, 8'hFE, 8'h02, rd, err, lat, tmo);
        model_xfer(1'b1, 8'h06, 8'h5A, erd, eerr, elat);
        do_xfer(1'b1, 8'h06, 8'h5A, rd, err, lat, tmo);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h06; PWDATA = 8'h99;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        n_tests++;
        if (PREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_wait_ready: got %b, want 0", PREADY);
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            n_tests++;
            if (PREADY !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_ready_cycle%0d: got %b, want 0", i, PREADY);
            end
        end
        @(posedge PCLK); #1;
        model_xfer(1'b0, 8'h06, 8'h00, erd, eerr, elat);
        do_xfer(1'b0, 8'h06, 8'h00, rd, err, lat, tmo);
        n_tests++;
        if (tmo || rd !== erd || err !== eerr) begin
            n_fail++;
            $display("FAIL abort_readback: got data %h err %b, want data %h err %b", rd, err, erd, eerr);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd, erd;
        logic       err, eerr;
        int         lat, elat;
        bit         tmo;
        model_xfer(1'b1, 8'h06, 8'h77, erd, eerr, elat);
        do_xfer(1'b1, 8'h06, 8'h77, rd, err, lat, tmo);
        model_xfer(1'b1, 8'hFE, 8'h03, erd, eerr, elat);
        do_xfer(1'b1, 8'hFE, 8'h03, rd, err, lat, tmo);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h06; PWDATA = 8'h12;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #2;
        PRESETn = 1'b0;
        #1;
        n_tests++;
        if ({PREADY, PSLVERR, PRDATA} !== 10'h000) begin
            n_fail++;
            $display("FAIL midreset_outputs: got ready=%b err=%b rdata=%h, want 0 0 00", PREADY, PSLVERR, PRDATA);
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        PRESETn = 1'b1;
        model_reset();
        idle(1);
        model_xfer(1'b0, 8'hFE, 8'h00, erd, eerr, elat);
        do_xfer(1'b0, 8'hFE, 8'h00, rd, err, lat, tmo);
        n_tests++;
        if (tmo || lat !== elat || rd !== erd) begin
            n_fail++;
            $display("FAIL midreset_wait_cfg: got lat %0d data %h, want lat %0d data %h", lat, rd, elat, erd);
        end
        model_xfer(1'b0, 8'h06, 8'h00, erd, eerr, elat);
        do_xfer(1'b0, 8'h06, 8'h00, rd, err, lat, tmo);
        n_tests++;
        if (tmo || rd !== erd) begin
            n_fail++;
            $display("FAIL midreset_reg_cleared: got %h, want %h", rd, erd);
        end
    endtask

    task automatic test_random();
        logic       w;
        logic [7:0] a, d, rd, erd;
        logic       err, eerr;
        int         lat, elat, sel;
        bit         tmo;
        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 5)      a = 8'($urandom_range(0, DEPTH - 1));
            else if (sel == 6) a = 8'hFE;
            else if (sel == 7) a = 8'hFF;
            else               a = 8'($urandom_range(DEPTH, 253));
            w = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            model_xfer(w, a, d, erd, eerr, elat);
            do_xfer(w, a, d, rd, err, lat, tmo);
            n_tests++;
            if (tmo || lat !== elat || err !== eerr || (!w && rd !== erd)) begin
                n_fail++;
                $display("FAIL rand%0d w=%b addr %h: got lat %0d err %b data %h, want lat %0d err %b data %h",
                         i, w, a, lat, err, rd, elat, eerr, erd);
            end
            idle(int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_slave_waitstate.md
Name: apb_slave_waitstate

Overview:
- Second APB completer for the PSEL2 / PADDR[8]=1 half of the APB address map.
- Consumes PSEL2, PENABLE, PWRITE, PADDR[7:0] and PWDATA from the master bridge; returns PRDATA2, PREADY2 and PSLVERR.
- Adds a byte register file, a run-time programmable wait-state count, a read-only ID register and error signalling for illegal accesses.

Parameters:
- DEPTH, 64, number of 8-bit storage registers at addresses 0x00..DEPTH-1 (legal range 1..254).
- DEFAULT_WAIT, 2, reset value of the WAIT_CFG register (0..7).
- ID_VALUE, 8'hA5, constant returned when address 0xFF is read.

Ports:
- PCLK  input  1  APB clock; all state updates on the rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- PSEL  input  1  slave select (PSEL2 from the bridge).
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  8  byte address (PADDR[7:0]).
- PWDATA  input  8  write data.
- PRDATA  output  8  read data; valid only while PREADY=1 on a read.
- PREADY  output  1  transfer-complete handshake.
- PSLVERR  output  1  error response; valid only while PREADY=1.

Behaviour:
- Reset (PRESETn=0, asynchronous):
  - state=IDLE, wait counter=0, all DEPTH registers=8'h00, WAIT_CFG=DEFAULT_WAIT.
  - PREADY=0, PSLVERR=0, PRDATA=8'h00.
- Address map:
  - 0x00..DEPTH-1: read/write storage.
  - 0xFE: WAIT_CFG, read/write, only bits [2:0] stored; reads return {5'b0, WAIT_CFG}.
  - 0xFF: ID, read-only; reads return ID_VALUE.
  - All other addresses: illegal.
- Error cases (PSLVERR=1 during the completion cycle): any access to an illegal address, and any write to 0xFF.
- Error write: no state is modified.
- Error read: PRDATA=8'h00.
- State machine:
  - IDLE: on PSEL=1 and PENABLE=0 (setup phase), latch PADDR, PWRITE and PWDATA and load cnt<=WAIT_CFG. Next state is DONE if WAIT_CFG==0, else WAIT.
  - WAIT: PREADY=0. If PSEL=0, abort to IDLE with no side effects. Otherwise decrement cnt; move to DONE when cnt==1.
  - DONE: PREADY=1 and PSLVERR/PRDATA are driven combinationally, qualified by PSEL&PENABLE.
    - Write commit (if legal) occurs on the edge ending this cycle.
    - Next state is always IDLE.
    - If PSEL=0 in DONE, there is no commit and no PREADY.
- Latency:
  - Setup cycle T0; PREADY=1 in cycle T0+1+WAIT_CFG.
  - WAIT_CFG=0 gives a zero-wait APB access (PREADY in T1).
- Back-to-back: the master may present a new setup phase in the cycle after DONE. IDLE accepts it, so the minimum transfer length is 2 cycles.
- The wait count is captured at setup. A write to WAIT_CFG affects only subsequent transfers, never the transfer in flight or the one writing it.
- Outside DONE: PREADY=0, PSLVERR=0, PRDATA=8'h00.
- Latched PADDR/PWDATA are used for decode and commit. Bus changes after setup (a protocol violation) are ignored.
- Reset asserted mid-transfer: immediate return to reset values. The pending write is discarded.
- PENABLE=1 seen in IDLE without a prior setup phase: ignored, no response.

Decomposition:
- Shared package apb_pkg holds:
  - state enum typedef {IDLE, WAIT, DONE};
  - address constants ADDR_WAIT_CFG=8'hFE and ADDR_ID=8'hFF;
  - data/address width constants (8).
- One natural sub-module: apb_regbank. It holds the DEPTH×8 storage plus WAIT_CFG, with write-enable/address/data in and combinational read out. The FSM, counter and error decode stay in the top module.

Test Plan:
- Reset then read 0x10: with WAIT_CFG=2, PREADY=1 exactly 3 cycles after setup; PRDATA=8'h00, PSLVERR=0.
- Write 8'h3C to 0x05, then read 0x05 -> PRDATA=8'h3C. Read 0xFF -> PRDATA=8'hA5. Read 0xFE -> PRDATA=8'h02.
- Write 8'h00 to 0xFE, then read 0x05 -> PREADY in the first access cycle (T1). Then write 8'h07 to 0xFE -> the next transfer completes at T8; the write to 0xFE itself completed at T1.
- Write 8'h11 to 0xFF and write 8'h22 to 0x40 (DEPTH=64) -> PSLVERR=1 with PREADY; a follow-up read of 0xFF returns 8'hA5; a read of 0x40 gives PSLVERR=1, PRDATA=8'h00.
- Write to 0x06 with PSEL dropped during WAIT -> no PREADY, and a subsequent read of 0x06 returns the old value. Repeat with PRESETn pulsed low mid-WAIT -> all outputs 0, WAIT_CFG=2, register contents cleared.
- Back-to-back writes to 0x01, 0x02, 0x03 with setup immediately after each completion -> each completes with WAIT_CFG spacing and all three values read back correctly.
